// File: rtl/jt51_pm_seq_if.sv
// Bus bundle for jt51_pm_seq: channel-register write port, LFO modulation
// inputs, clock enable and the extended key-code output stream.
// Optional macro JT51_PM_STATS_EN adds the sat_cnt saturation counter signal.
interface jt51_pm_seq_if #(
    parameter int CH = 8,
    parameter int MW = 9
);
    localparam int CW = $clog2(CH);

    logic          cen;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [6:0]    wr_kc;
    logic [5:0]    wr_kf;
    logic [MW-1:0] mod;
    logic          add;
    logic [12:0]   kcex;
    logic [CW-1:0] kcex_ch;
    logic          kcex_valid;
`ifdef JT51_PM_STATS_EN
    logic [7:0]    sat_cnt;
`endif

    modport master (
        output cen, wr_en, wr_ch, wr_kc, wr_kf, mod, add,
        input  kcex, kcex_ch, kcex_valid
`ifdef JT51_PM_STATS_EN
        , input sat_cnt
`endif
    );

    modport slave (
        input  cen, wr_en, wr_ch, wr_kc, wr_kf, mod, add,
        output kcex, kcex_ch, kcex_valid
`ifdef JT51_PM_STATS_EN
        , output sat_cnt
`endif
    );
endinterface

// File: rtl/jt51_pm_seq.sv
// Time-multiplexed key-code phase modulator for the JT51 operator path.
// Walks CH channels one slot per cen, applies the shared LFO modulation and
// emits a saturated extended key code {oct, note, kf} three cen edges later.
// Optional macro JT51_PM_STATS_EN compiles in the 8-bit sticky sat_cnt output.
module jt51_pm_seq #(
    parameter int CH = 8,
    parameter int MW = 9
) (
    input  logic             clk,
    input  logic             rst,
    jt51_pm_seq_if.slave     pm
);
    localparam int          CW     = $clog2(CH);
    localparam logic [14:0] S_MAX  = 15'd6143;
    localparam logic [12:0] R_MAX  = 13'd6143;

    // Semitone (0..95) to {octave, semitone-in-octave} table, 7 bits per entry.
    function automatic logic [671:0] build_div12();
        logic [671:0] lut;
        lut = '0;
        for (int i = 0; i < 96; i++) begin
            lut[i*7 +: 7] = {3'(i / 12), 4'(i % 12)};
        end
        return lut;
    endfunction
    localparam logic [671:0] DIV12 = build_div12();

    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    kc_q [CH];
    logic [5:0]    kf_q [CH];

    logic [6:0]    s1_kc_q, s1_kc_d;
    logic          s1_ovf_q, s1_ovf_d;
    logic [5:0]    s1_kf_q;
    logic [MW-1:0] s1_mod_q;
    logic          s1_add_q;
    logic [CW-1:0] s1_ch_q;
    logic          s1_v_q;

    logic [14:0]   s2_s_q, s2_s_d;
    logic          s2_force_q;
    logic [CW-1:0] s2_ch_q;
    logic          s2_v_q;

    logic [12:0]   kcex_q, kcex_d;
    logic [CW-1:0] kcex_ch_q;
    logic          kcex_valid_q;

    logic [3:0]    idx_s2;
    logic [6:0]    sem_s2;
    logic [12:0]   r_s3;
    logic [6:0]    map_s3;
    logic [3:0]    note_s3;

    // Slot counter wraps naturally because CH is a power of two.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    // Channel registers: written on any clk edge, independent of cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                kc_q[i] <= '0;
                kf_q[i] <= '0;
            end
        end else if (pm.wr_en) begin
            kc_q[pm.wr_ch] <= pm.wr_kc;
            kf_q[pm.wr_ch] <= pm.wr_kf;
        end
    end

    // S1 cleaning: illegal note x3 bumps to the next legal note; a carry out
    // of 0x7F marks the slot for forced high saturation.
    always_comb begin
        logic [7:0] sum;
        sum      = {1'b0, kc_q[cnt_q]} + ((kc_q[cnt_q][1:0] == 2'b11) ? 8'd1 : 8'd0);
        s1_kc_d  = sum[6:0];
        s1_ovf_d = sum[7];
    end

    // S2: linear pitch {semitone, kf} plus or minus the modulation.
    always_comb begin
        idx_s2 = s1_kc_q[3:0] - {2'b00, s1_kc_q[3:2]};
        sem_s2 = 7'(s1_kc_q[6:4]) * 7'd12 + 7'(idx_s2);
        if (s1_add_q) begin
            s2_s_d = {2'b00, sem_s2, s1_kf_q} + 15'(s1_mod_q);
        end else begin
            s2_s_d = {2'b00, sem_s2, s1_kf_q} - 15'(s1_mod_q);
        end
    end

    // S3: clamp to 0..6143 and convert back to {oct, note, kf}.
    always_comb begin
        if (s2_force_q) begin
            r_s3 = R_MAX;
        end else if (s2_s_q[14]) begin
            r_s3 = '0;
        end else if (s2_s_q > S_MAX) begin
            r_s3 = R_MAX;
        end else begin
            r_s3 = s2_s_q[12:0];
        end
        map_s3 = DIV12[int'(r_s3[12:6])*7 +: 7];
        if (map_s3[3:0] >= 4'd9) begin
            note_s3 = map_s3[3:0] + 4'd3;
        end else if (map_s3[3:0] >= 4'd6) begin
            note_s3 = map_s3[3:0] + 4'd2;
        end else if (map_s3[3:0] >= 4'd3) begin
            note_s3 = map_s3[3:0] + 4'd1;
        end else begin
            note_s3 = map_s3[3:0];
        end
        kcex_d = {map_s3[6:4], note_s3, r_s3[5:0]};
    end

    // Slot counter and three pipeline stages, all gated by cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            s1_kc_q      <= '0;
            s1_ovf_q     <= 1'b0;
            s1_kf_q      <= '0;
            s1_mod_q     <= '0;
            s1_add_q     <= 1'b0;
            s1_ch_q      <= '0;
            s1_v_q       <= 1'b0;
            s2_s_q       <= '0;
            s2_force_q   <= 1'b0;
            s2_ch_q      <= '0;
            s2_v_q       <= 1'b0;
            kcex_q       <= '0;
            kcex_ch_q    <= '0;
            kcex_valid_q <= 1'b0;
        end else if (pm.cen) begin
            cnt_q        <= cnt_d;
            s1_kc_q      <= s1_kc_d;
            s1_ovf_q     <= s1_ovf_d;
            s1_kf_q      <= kf_q[cnt_q];
            s1_mod_q     <= pm.mod;
            s1_add_q     <= pm.add;
            s1_ch_q      <= cnt_q;
            s1_v_q       <= 1'b1;
            s2_s_q       <= s2_s_d;
            s2_force_q   <= s1_ovf_q;
            s2_ch_q      <= s1_ch_q;
            s2_v_q       <= s1_v_q;
            kcex_q       <= kcex_d;
            kcex_ch_q    <= s2_ch_q;
            kcex_valid_q <= s2_v_q;
        end
    end

    assign pm.kcex       = kcex_q;
    assign pm.kcex_ch    = kcex_ch_q;
    assign pm.kcex_valid = kcex_valid_q;

`ifdef JT51_PM_STATS_EN
    logic [7:0] sat_cnt_q;
    logic       sat_s3;

    // A slot saturates when forced or when the clamp hits either bound.
    always_comb begin
        sat_s3 = s2_force_q | s2_s_q[14] | (s2_s_q > S_MAX);
    end

    // Sticky saturation counter, advanced on the S3 load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (pm.cen && s2_v_q && sat_s3 && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_q <= sat_cnt_q + 8'd1;
        end
    end

    assign pm.sat_cnt = sat_cnt_q;
`endif
endmodule

// File: tb/tb_jt51_pm_seq.sv
// Self-checking bench for jt51_pm_seq: reset/zero sweep, a table of
// per-channel vectors, cen 1-of-3 with a same-edge write, and mid-run reset.
module tb_jt51_pm_seq;
    logic clk;
    logic rst;

    jt51_pm_seq_if #(.CH(8), .MW(9)) pm ();

    jt51_pm_seq #(.CH(8), .MW(9)) dut (
        .clk (clk),
        .rst (rst),
        .pm  (pm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  kc;
        logic [5:0]  kf;
        logic [8:0]  md;
        logic        ad;
        logic [12:0] exp_kcex;
        logic        sat;
    } vec_t;

    vec_t tv [8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;
    int   sat_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    initial begin
        tv[0] = '{7'h00, 6'd0,  9'd0,   1'b1, 13'h0000, 1'b0};
        tv[1] = '{7'h4A, 6'd32, 9'd100, 1'b1, 13'h1344, 1'b0};
        tv[2] = '{7'h00, 6'd10, 9'd20,  1'b0, 13'h0000, 1'b1};
        tv[3] = '{7'h7E, 6'd63, 9'd1,   1'b1, 13'h1FBF, 1'b1};
        tv[4] = '{7'h7F, 6'd0,  9'd0,   1'b0, 13'h1FBF, 1'b1};
        tv[5] = '{7'h23, 6'd0,  9'd0,   1'b1, 13'h0900, 1'b0};
        tv[6] = '{7'h15, 6'd5,  9'd300, 1'b0, 13'h0399, 1'b0};
        tv[7] = '{7'h7E, 6'd0,  9'd511, 1'b0, 13'h1D01, 1'b0};

        // Phase A: reset state, then all-zero channels with mod=0
        rst = 1'b1; pm.cen = 1'b1; pm.wr_en = 1'b0; pm.wr_ch = '0;
        pm.wr_kc = '0; pm.wr_kf = '0; pm.mod = '0; pm.add = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(pm.kcex_valid), 32'd0);
        chk("reset_kcex", 32'(pm.kcex), 32'd0);
        chk("reset_ch", 32'(pm.kcex_ch), 32'd0);
`ifdef JT51_PM_STATS_EN
        chk("reset_sat_cnt", 32'(pm.sat_cnt), 32'd0);
`endif
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            chk("zero_valid", 32'(pm.kcex_valid), 32'(n >= 3));
            if (n >= 3) begin
                chk("zero_ch", 32'(pm.kcex_ch), 32'((n - 3) % 8));
                chk("zero_kcex", 32'(pm.kcex), 32'd0);
            end
        end

        // Phase B: table-driven vectors, channels written while cen is low
        rst = 1'b1; pm.cen = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            pm.wr_en = 1'b1; pm.wr_ch = 3'(c); pm.wr_kc = tv[c].kc; pm.wr_kf = tv[c].kf;
            @(posedge clk); @(negedge clk);
        end
        pm.wr_en = 1'b0;
        chk("frozen_valid", 32'(pm.kcex_valid), 32'd0);
        n = 0; sat_exp = 0;
        pm.mod = tv[0].md; pm.add = tv[0].ad; pm.cen = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (n >= 3) begin
                chk("vec_ch", 32'(pm.kcex_ch), 32'((n - 3) % 8));
                chk($sformatf("vec_kcex_ch%0d", (n - 3) % 8), 32'(pm.kcex), 32'(tv[(n - 3) % 8].exp_kcex));
                if (tv[(n - 3) % 8].sat) sat_exp++;
`ifdef JT51_PM_STATS_EN
                chk("vec_sat_cnt", 32'(pm.sat_cnt), 32'(sat_exp));
`endif
            end
            pm.mod = tv[n % 8].md; pm.add = tv[n % 8].ad;
        end

        // Phase C: cen 1-of-3, write to channel 2 on the edge that samples it
        rst = 1'b1; pm.cen = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        pm.wr_en = 1'b1; pm.wr_ch = 3'd2; pm.wr_kc = 7'h4A; pm.wr_kf = 6'd32;
        @(posedge clk); @(negedge clk);
        pm.wr_en = 1'b0; pm.mod = 9'd100; pm.add = 1'b1;
        n = 0;
        for (int i = 0; i < 66; i++) begin
            pm.cen = (i % 3 == 0);
            if (pm.cen && n == 2) begin
                pm.wr_en = 1'b1; pm.wr_ch = 3'd2; pm.wr_kc = 7'h23; pm.wr_kf = 6'd0;
            end else begin
                pm.wr_en = 1'b0;
            end
            @(posedge clk);
            if (pm.cen) n++;
            @(negedge clk);
            chk("cen_valid", 32'(pm.kcex_valid), 32'(n >= 3));
            if (n >= 3) begin
                chk("cen_ch", 32'(pm.kcex_ch), 32'((n - 3) % 8));
                if ((n - 3) % 8 == 2) begin
                    chk("cen_kcex_ch2", 32'(pm.kcex), (n < 13) ? 32'h1344 : 32'h0964);
                end else begin
                    chk("cen_kcex", 32'(pm.kcex), 32'h0064);
                end
            end
        end
        pm.wr_en = 1'b0;

        // Mid-stream reset: valid drops on the reset edge, returns after 3 cen edges
        rst = 1'b1; pm.cen = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_valid", 32'(pm.kcex_valid), 32'd0);
        chk("midrst_kcex", 32'(pm.kcex), 32'd0);
        chk("midrst_ch", 32'(pm.kcex_ch), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            chk("rel_valid", 32'(pm.kcex_valid), 32'(n >= 3));
            if (n >= 3) begin
                chk("rel_ch", 32'(pm.kcex_ch), 32'((n - 3) % 8));
                chk("rel_kcex", 32'(pm.kcex), 32'h0064);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
